// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-road traffic light sequencer.
// The main road rests on green. Side-road car requests and pedestrian requests
// are latched and served after a guaranteed minimum main green. Every green is
// preceded by an all-red or pedestrian phase.
// Optional feature: define FLASH_EN to add the `flash` input and the FLASH
// state. In FLASH, both roads blink and the pedestrian walk lamp stays off.
// Reset is asynchronous and active-low on port `rst`.
// `phase` exposes the state register for debug.
module intersection_scheduler #(
  parameter int G_MIN   = 512,
  parameter int Y_CYC   = 256,
  parameter int AR_CYC  = 64,
  parameter int PED_CYC = 128,
  parameter int CW      = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_side,
  input  logic       ped_req,
`ifdef FLASH_EN
  input  logic       flash,
`endif
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       ped_walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    ALLR1  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    ALLR2  = 3'd5,
    PED    = 3'd6
`ifdef FLASH_EN
    ,FLASH = 3'd7
`endif
  } state_t;

  // The last count value of each timed phase.
  localparam logic [CW-1:0] G_LAST   = CW'(G_MIN - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(Y_CYC - 1);
  localparam logic [CW-1:0] AR_LAST  = CW'(AR_CYC - 1);
  localparam logic [CW-1:0] PED_LAST = CW'(PED_CYC - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          side_pend;
  logic          ped_pend;
  // Set when PED was entered from ALLR2. That PED must always return to MAIN_G.
  logic          ped_from_ar2;
`ifdef FLASH_EN
  logic          toggle;
`endif

  // Phase sequencer: state, phase counter and request latches in one block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= MAIN_G;
      cnt          <= '0;
      side_pend    <= 1'b0;
      ped_pend     <= 1'b0;
      ped_from_ar2 <= 1'b0;
`ifdef FLASH_EN
      toggle       <= 1'b0;
`endif
    end else begin
      // Default: latch new requests and advance the phase counter.
      // Later assignments in the case below take precedence.
      side_pend <= side_pend | req_side;
      ped_pend  <= ped_pend | ped_req;
      cnt       <= cnt + 1'b1;
`ifdef FLASH_EN
      if (flash) begin
        if (state != FLASH) begin
          state  <= FLASH;
          cnt    <= '0;
          toggle <= 1'b0;
        end else if (cnt[4:0] == 5'd31) begin
          toggle <= ~toggle;
        end
      end else
`endif
      case (state)
        MAIN_G: begin
          if (cnt >= G_LAST) begin
            if (side_pend || ped_pend) begin
              state <= MAIN_Y;
              cnt   <= '0;
            end else begin
              // Saturate so that a later request is served at once.
              cnt <= G_LAST;
            end
          end
        end
        MAIN_Y: begin
          if (cnt == Y_LAST) begin
            state <= ALLR1;
            cnt   <= '0;
          end
        end
        ALLR1: begin
          if (cnt == AR_LAST) begin
            cnt <= '0;
            if (ped_pend) begin
              state        <= PED;
              ped_pend     <= 1'b0;
              ped_from_ar2 <= 1'b0;
            end else begin
              state     <= SIDE_G;
              side_pend <= 1'b0;
            end
          end
        end
        SIDE_G: begin
          if (cnt == G_LAST) begin
            state <= SIDE_Y;
            cnt   <= '0;
          end
        end
        SIDE_Y: begin
          if (cnt == Y_LAST) begin
            state <= ALLR2;
            cnt   <= '0;
          end
        end
        ALLR2: begin
          if (cnt == AR_LAST) begin
            cnt <= '0;
            if (ped_pend) begin
              state        <= PED;
              ped_pend     <= 1'b0;
              ped_from_ar2 <= 1'b1;
            end else begin
              state <= MAIN_G;
            end
          end
        end
        PED: begin
          if (cnt == PED_LAST) begin
            cnt <= '0;
            if (side_pend && !ped_from_ar2) begin
              state     <= SIDE_G;
              side_pend <= 1'b0;
            end else begin
              state <= MAIN_G;
            end
          end
        end
`ifdef FLASH_EN
        FLASH: begin
          // Flash has been released. Clear the junction before normal service resumes.
          state <= ALLR2;
          cnt   <= '0;
        end
`endif
        default: begin
          state <= MAIN_G;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Moore lamp decode taken straight from the state register.
  always_comb begin
    main_rgy = 3'b100;
    side_rgy = 3'b100;
    ped_walk = 1'b0;
    case (state)
      MAIN_G: main_rgy = 3'b010;
      MAIN_Y: main_rgy = 3'b001;
      SIDE_G: side_rgy = 3'b010;
      SIDE_Y: side_rgy = 3'b001;
      PED:    ped_walk = 1'b1;
`ifdef FLASH_EN
      FLASH: begin
        main_rgy = {2'b00, toggle};
        side_rgy = {toggle, 2'b00};
      end
`endif
      default: begin
        main_rgy = 3'b100;
        side_rgy = 3'b100;
      end
    endcase
  end

  assign phase = state;

endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
- Two-road intersection controller that sequences a main road and a side road through green/yellow/all-red phases. Arbitrates between side-road car requests and pedestrian crossing requests.
- Main road rests on green. Side road and pedestrians are served on demand, after a guaranteed minimum main green.
- Sits above the single-road light generator and drives both roads' R/G/Y lamps plus a walk lamp.

Parameters:
- G_MIN, 512: minimum green length in cycles; also the fixed side-road green length.
- Y_CYC, 256: yellow length in cycles.
- AR_CYC, 64: all-red clearance length in cycles.
- PED_CYC, 128: pedestrian walk length in cycles.
- CW, 12: phase counter width; must satisfy 2^CW > max(G_MIN, Y_CYC, AR_CYC, PED_CYC).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_side  in  1  side-road car sensor pulse; any width ≥1 cycle.
- ped_req  in  1  pedestrian button pulse; any width ≥1 cycle.
- main_rgy  out  3  main road lamps {R,G,Y}.
- side_rgy  out  3  side road lamps {R,G,Y}.
- ped_walk  out  1  walk lamp.
- phase  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: MAIN_G=0, MAIN_Y=1, ALLR1=2, SIDE_G=3, SIDE_Y=4, ALLR2=5, PED=6. FLASH=7 exists only with the optional feature.
- Outputs are Moore, decoded combinationally from the state register.
- Lamp values:
  - MAIN_G: main 010, side 100.
  - MAIN_Y: main 001, side 100.
  - SIDE_G: main 100, side 010.
  - SIDE_Y: main 100, side 001.
  - ALLR1, ALLR2, PED: main 100, side 100.
  - ped_walk=1 only in PED.
- Reset (rst=0, async): state MAIN_G, cnt=0, side_pend=0, ped_pend=0. Outputs are immediately main 010, side 100, walk 0, phase 0.
- Cycle numbering: cycle 0 is the first rising edge with rst=1. cnt=0 in the first cycle of each state and increments every cycle.
- Request latches:
  - req_side sampled high at an edge sets side_pend, visible the next cycle.
  - ped_req likewise sets ped_pend.
  - side_pend clears on entry to SIDE_G. ped_pend clears on entry to PED.
  - A request sampled on the same edge as its clear is consumed, not re-latched. Set otherwise wins over hold.
- Transitions (all taken at the clock edge):
  - MAIN_G → MAIN_Y when cnt ≥ G_MIN-1 and (side_pend | ped_pend). Otherwise hold. cnt saturates at G_MIN-1.
  - MAIN_Y → ALLR1 at cnt = Y_CYC-1.
  - ALLR1 → PED if ped_pend, else SIDE_G, at cnt = AR_CYC-1.
  - PED → SIDE_G if side_pend, else MAIN_G, at cnt = PED_CYC-1. Only valid when PED was entered from ALLR1.
  - SIDE_G → SIDE_Y at cnt = G_MIN-1. The side green length is fixed.
  - SIDE_Y → ALLR2 at cnt = Y_CYC-1.
  - ALLR2 → PED if ped_pend, else MAIN_G, at cnt = AR_CYC-1. PED entered from ALLR2 always exits to MAIN_G; a flag records the entry origin.
- Every transition resets cnt to 0.
- Lamp safety: conflicting greens are never possible. Every green is preceded by an all-red or PED state.
- Requests arriving during any non-MAIN_G state are latched and served in order: pedestrian at the next all-red, side at the next side slot.

Optional Feature:
- Macro: FLASH_EN.
- When defined, adds input port `flash` (1 bit).
- flash=1 forces FLASH from any state on the next edge. Latches are preserved.
- In FLASH, a toggle bit flips every 32 cycles. Main shows {0,0,toggle}; side shows {toggle,0,0}; walk=0.
- On flash deassertion: FLASH → ALLR2 with cnt=0, then normal operation.
- When undefined: no `flash` port, no FLASH state, phase never equals 7.

Test Plan:
- No requests: release rst, run 2000 cycles → main_rgy=010, side_rgy=100, ped_walk=0, phase=0 throughout.
- Early side request: req_side pulse at cycle 100 → MAIN_Y at cycle 512, ALLR1 at 768, SIDE_G at 832, SIDE_Y at 1344, ALLR2 at 1600, MAIN_G at 1664.
- Late side request: req_side pulse at cycle 900 → side_pend=1 at 901, MAIN_Y at 902.
- Pedestrian only: ped_req at cycle 100 → MAIN_Y 512, ALLR1 768, PED 832 with walk=1 for exactly 128 cycles, MAIN_G at 960, side never green.
- Pedestrian and side both pending, with a mid-phase reset: req_side and ped_req both at cycle 50 → PED at 832, SIDE_G at 960, both latches 0 afterwards. Then assert rst=0 at cycle 1100 (in SIDE_G) → outputs main 010, side 100 in the same cycle, no clock edge needed.
- With FLASH_EN: flash=1 at cycle 300 → phase=7 at 301; main Y toggles every 32 cycles; flash=0 at 600 → ALLR2 at 601, MAIN_G at 665.
